// File: rtl/rgb_seq_pkg.sv
// Shared types and default 640x480 raster constants for the RGB DAC sequencer.
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    RGB_MODE_BLACK = 2'd0,
    RGB_MODE_BARS  = 2'd1,
    RGB_MODE_RAMP  = 2'd2,
    RGB_MODE_SWEEP = 2'd3
  } rgb_mode_e;

  // Counter width; covers raster totals up to 4095.
  localparam int CNT_W = 12;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int H_SYNC_START = DEF_H_VIS + DEF_H_FP;
  localparam int H_SYNC_END   = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_VIS + DEF_V_FP;
  localparam int V_SYNC_END   = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC - 1;

endpackage

// File: rtl/rgb_seq_timing.sv
// Raster h/v counters with visible-area, sync-window and end-of-frame decode.
module rgb_seq_timing
  import rgb_seq_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             vis,
  output logic             hs_act,
  output logic             vs_act,
  output logic             line_end,
  output logic             eof
);

  localparam int HT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HSS = H_VIS + H_FP;
  localparam int HSE = H_VIS + H_FP + H_SYNC - 1;
  localparam int VSS = V_VIS + V_FP;
  localparam int VSE = V_VIS + V_FP + V_SYNC - 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (line_end) begin
      h <= '0;
      v <= eof ? '0 : v + CNT_W'(1);
    end else begin
      h <= h + CNT_W'(1);
    end
  end

  assign line_end = (h == CNT_W'(HT - 1));
  assign eof      = line_end && (v == CNT_W'(VT - 1));
  assign vis      = (h < CNT_W'(H_VIS)) && (v < CNT_W'(V_VIS));
  assign hs_act   = (h >= CNT_W'(HSS)) && (h <= CNT_W'(HSE));
  assign vs_act   = (v >= CNT_W'(VSS)) && (v <= CNT_W'(VSE));

endmodule

// File: rtl/rgb_dac_sequencer.sv
// VGA-class raster and test-pattern source feeding three 8-bit colour DACs;
// pattern configuration is latched only at end of frame so frames never tear.
module rgb_dac_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [2:0] chan_en,
  output logic [7:0] dr,
  output logic [7:0] dg,
  output logic [7:0] db,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int BAR_W = H_VIS / 8;

  function automatic logic [7:0] bar_level(input logic on);
    return on ? 8'hFF : 8'h00;
  endfunction

  logic [CNT_W-1:0] h, v;
  logic             vis, hs_act, vs_act, line_end, eof;

  rgb_seq_timing #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .h        (h),
    .v        (v),
    .vis      (vis),
    .hs_act   (hs_act),
    .vs_act   (vs_act),
    .line_end (line_end),
    .eof      (eof)
  );

  rgb_mode_e  mode_q;
  logic [2:0] chan_q;
  logic [7:0] frame_cnt_q;
  logic       started;

  // frame_start is suppressed until the first EOF after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= RGB_MODE_BLACK;
      chan_q      <= 3'b111;
      frame_cnt_q <= 8'd0;
      started     <= 1'b0;
    end else if (eof) begin
      mode_q      <= rgb_mode_e'(mode);
      chan_q      <= chan_en;
      frame_cnt_q <= frame_cnt_q + 8'd1;
      started     <= 1'b1;
    end
  end

  logic [CNT_W-1:0] sub_cnt;
  logic [2:0]       bar_cnt;

  // Bar position tracks h without a divider: sub_cnt = h % BAR_W, bar_cnt = h / BAR_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= '0;
      bar_cnt <= 3'd0;
    end else if (line_end) begin
      sub_cnt <= '0;
      bar_cnt <= 3'd0;
    end else if (sub_cnt == CNT_W'(BAR_W - 1)) begin
      sub_cnt <= '0;
      bar_cnt <= bar_cnt + 3'd1;
    end else begin
      sub_cnt <= sub_cnt + CNT_W'(1);
    end
  end

  logic [7:0] pix_r, pix_g, pix_b;
  logic [2:0] bar_code;

  always_comb begin
    pix_r    = 8'h00;
    pix_g    = 8'h00;
    pix_b    = 8'h00;
    bar_code = 3'd7 - bar_cnt;
    case (mode_q)
      RGB_MODE_BARS: begin
        pix_r = bar_level(bar_code[2]);
        pix_g = bar_level(bar_code[1]);
        pix_b = bar_level(bar_code[0]);
      end
      RGB_MODE_RAMP: begin
        pix_r = h[7:0];
        pix_g = h[7:0];
        pix_b = h[7:0];
      end
      RGB_MODE_SWEEP: begin
        pix_r = frame_cnt_q;
        pix_g = frame_cnt_q;
        pix_b = frame_cnt_q;
      end
      default: ;
    endcase
  end

  logic [7:0] dr_p0, dg_p0, db_p0;
  logic       hsync_p0, vsync_p0, vld_p0, fs_p0;

  // Output stage p0: one register for every output keeps them mutually aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dr_p0    <= 8'h00;
      dg_p0    <= 8'h00;
      db_p0    <= 8'h00;
      hsync_p0 <= ~SYNC_POL;
      vsync_p0 <= ~SYNC_POL;
      vld_p0   <= 1'b0;
      fs_p0    <= 1'b0;
    end else begin
      dr_p0    <= vis ? (pix_r & {8{chan_q[2]}}) : 8'h00;
      dg_p0    <= vis ? (pix_g & {8{chan_q[1]}}) : 8'h00;
      db_p0    <= vis ? (pix_b & {8{chan_q[0]}}) : 8'h00;
      hsync_p0 <= hs_act ? SYNC_POL : ~SYNC_POL;
      vsync_p0 <= vs_act ? SYNC_POL : ~SYNC_POL;
      vld_p0   <= vis;
      fs_p0    <= started && (h == '0) && (v == '0);
    end
  end

  assign dr          = dr_p0;
  assign dg          = dg_p0;
  assign db          = db_p0;
  assign hsync       = hsync_p0;
  assign vsync       = vsync_p0;
  assign blank       = ~vld_p0;
  assign frame_start = fs_p0;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_rgb_dac_sequencer.sv
// Directed bench: a reduced raster (wide enough for ramp wrap) plus a tiny raster for the 258-frame sweep.
module tb_rgb_dac_sequencer;

  // Main instance geometry: 280 x 7, 1960 clocks per frame
  localparam int HT = 264 + 4 + 6 + 6;
  localparam int VT = 3 + 1 + 2 + 1;
  localparam int FR = HT * VT;
  // Sweep instance geometry: 11 x 5, 55 clocks per frame
  localparam int HTS = 8 + 1 + 1 + 1;
  localparam int VTS = 2 + 1 + 1 + 1;
  localparam int FRS = HTS * VTS;

  logic       clk = 1'b0;
  logic       rst_n, rst_s_n;
  logic [1:0] mode, mode_s;
  logic [2:0] chan_en, chan_s;
  logic [7:0] dr, dg, db, frame_cnt;
  logic       hsync, vsync, blank, frame_start;
  logic [7:0] dr_s, dg_s, db_s, frame_cnt_s;
  logic       hsync_s, vsync_s, blank_s, frame_start_s;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;
  int pos_s    = 0;

  always #5 clk = ~clk;

  rgb_dac_sequencer #(
    .H_VIS(264), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_VIS(3),   .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .chan_en(chan_en),
    .dr(dr), .dg(dg), .db(db), .hsync(hsync), .vsync(vsync), .blank(blank),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  rgb_dac_sequencer #(
    .H_VIS(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_VIS(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst_n(rst_s_n), .mode(mode_s), .chan_en(chan_s),
    .dr(dr_s), .dg(dg_s), .db(db_s), .hsync(hsync_s), .vsync(vsync_s), .blank(blank_s),
    .frame_start(frame_start_s), .frame_cnt(frame_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance until the outputs show counter state (f, vl, hp) of the main instance.
  task automatic go(input int f, input int vl, input int hp);
    int e;
    e = f * FR + vl * HT + hp;
    while (pos <= e) begin
      @(posedge clk);
      pos++;
    end
    @(negedge clk);
  endtask

  task automatic go_s(input int f, input int vl, input int hp);
    int e;
    e = f * FRS + vl * HTS + hp;
    while (pos_s <= e) begin
      @(posedge clk);
      pos_s++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    rst_s_n = 1'b0;
    mode    = 2'd1;
    chan_en = 3'b111;
    mode_s  = 2'd3;
    chan_s  = 3'b111;
    repeat (3) @(negedge clk);

    check("rst_rgb",    {8'h0, dr, dg, db}, 32'h0);
    check("rst_hsync",  {31'h0, hsync}, 32'h1);
    check("rst_vsync",  {31'h0, vsync}, 32'h1);
    check("rst_blank",  {31'h0, blank}, 32'h1);
    check("rst_fs",     {31'h0, frame_start}, 32'h0);
    check("rst_fcnt",   {24'h0, frame_cnt}, 32'h0);

    rst_n = 1'b1;
    pos   = 0;

    // Frame 0: BARS requested but first frame is black
    go(0, 0, 0);
    check("f0_rgb_p0",  {8'h0, dr, dg, db}, 32'h0);
    check("f0_blank",   {31'h0, blank}, 32'h0);
    check("f0_fs",      {31'h0, frame_start}, 32'h0);
    check("f0_hsync",   {31'h0, hsync}, 32'h1);
    go(0, 0, 40);
    check("f0_rgb_p40", {8'h0, dr, dg, db}, 32'h0);
    go(0, 2, 200);
    check("f0_rgb_l2",  {8'h0, dr, dg, db}, 32'h0);
    go(0, 6, 279);
    check("f0_fs_last", {31'h0, frame_start}, 32'h0);

    // Frame 1: colour bars, 33 px wide
    go(1, 0, 0);
    check("f1_fs",      {31'h0, frame_start}, 32'h1);
    check("f1_fcnt",    {24'h0, frame_cnt}, 32'h1);
    check("bar0_p0",    {8'h0, dr, dg, db}, 32'hFFFFFF);
    go(1, 0, 1);
    check("f1_fs_off",  {31'h0, frame_start}, 32'h0);
    go(1, 0, 32);
    check("bar0_p32",   {8'h0, dr, dg, db}, 32'hFFFFFF);
    go(1, 0, 33);
    check("bar1_p33",   {8'h0, dr, dg, db}, 32'hFFFF00);
    go(1, 0, 66);
    check("bar2_p66",   {8'h0, dr, dg, db}, 32'hFF00FF);
    go(1, 0, 231);
    check("bar7_p231",  {8'h0, dr, dg, db}, 32'h000000);
    go(1, 0, 263);
    check("bar7_p263",  {8'h0, dr, dg, db}, 32'h000000);
    check("vis_p263",   {31'h0, blank}, 32'h0);
    go(1, 0, 264);
    check("blank_p264", {31'h0, blank}, 32'h1);
    check("rgb_p264",   {8'h0, dr, dg, db}, 32'h0);
    go(1, 0, 267);
    check("hs_pre",     {31'h0, hsync}, 32'h1);
    go(1, 0, 268);
    check("hs_first",   {31'h0, hsync}, 32'h0);
    go(1, 0, 273);
    check("hs_last",    {31'h0, hsync}, 32'h0);
    go(1, 0, 274);
    check("hs_post",    {31'h0, hsync}, 32'h1);

    // Mid-frame request for RAMP on green only; must not show until frame 2
    mode    = 2'd2;
    chan_en = 3'b010;
    go(1, 1, 10);
    check("midchg_hold", {8'h0, dr, dg, db}, 32'hFFFFFF);
    go(1, 3, 0);
    check("vs_pre",     {31'h0, vsync}, 32'h1);
    check("blank_l3",   {31'h0, blank}, 32'h1);
    go(1, 4, 0);
    check("vs_first",   {31'h0, vsync}, 32'h0);
    go(1, 5, 279);
    check("vs_last",    {31'h0, vsync}, 32'h0);
    go(1, 6, 0);
    check("vs_post",    {31'h0, vsync}, 32'h1);

    // Frame 2: ramp on green
    go(2, 0, 0);
    check("f2_fs",      {31'h0, frame_start}, 32'h1);
    check("ramp_p0",    {8'h0, dr, dg, db}, 32'h000000);
    go(2, 0, 5);
    check("ramp_p5",    {8'h0, dr, dg, db}, 32'h000500);
    go(2, 0, 255);
    check("ramp_p255",  {8'h0, dr, dg, db}, 32'h00FF00);
    go(2, 0, 256);
    check("ramp_p256",  {8'h0, dr, dg, db}, 32'h000000);
    go(2, 0, 263);
    check("ramp_p263",  {8'h0, dr, dg, db}, 32'h000700);

    // Inputs valid only during the EOF cycle
    go(2, 6, 278);
    mode    = 2'd1;
    chan_en = 3'b111;
    go(2, 6, 279);
    mode    = 2'd2;
    chan_en = 3'b111;
    go(3, 0, 0);
    check("eof_bars_p0",  {8'h0, dr, dg, db}, 32'hFFFFFF);
    check("f3_fcnt",      {24'h0, frame_cnt}, 32'h3);
    go(3, 0, 66);
    check("eof_bars_p66", {8'h0, dr, dg, db}, 32'hFF00FF);

    // Frame 4: full ramp, then mode change and asynchronous reset mid-frame
    go(4, 0, 7);
    check("f4_ramp_p7", {8'h0, dr, dg, db}, 32'h070707);
    check("f4_fcnt",    {24'h0, frame_cnt}, 32'h4);
    go(4, 1, 0);
    mode = 2'd1;
    go(4, 2, 40);
    check("f4_hold_ramp", {8'h0, dr, dg, db}, 32'h282828);
    go(4, 2, 100);
    rst_n = 1'b0;
    #1;
    check("arst_rgb",   {8'h0, dr, dg, db}, 32'h0);
    check("arst_blank", {31'h0, blank}, 32'h1);
    check("arst_hsync", {31'h0, hsync}, 32'h1);
    check("arst_fcnt",  {24'h0, frame_cnt}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pos   = 0;
    go(0, 0, 0);
    check("post_rst_p0",  {8'h0, dr, dg, db}, 32'h0);
    check("post_rst_vis", {31'h0, blank}, 32'h0);
    go(0, 1, 50);
    check("post_rst_l1",  {8'h0, dr, dg, db}, 32'h0);
    go(1, 0, 0);
    check("post_rst_f1",  {8'h0, dr, dg, db}, 32'hFFFFFF);
    check("post_rst_fs",  {31'h0, frame_start}, 32'h1);

    // Sweep across 258 frames on the small raster, including the 255 -> 0 wrap
    rst_s_n = 1'b1;
    pos_s   = 0;
    go_s(0, 0, 0);
    check("sw_f0", {8'h0, dr_s, dg_s, db_s}, 32'h0);
    for (int f = 1; f <= 258; f++) begin
      logic [7:0] c;
      c = 8'(f % 256);
      go_s(f, 0, 0);
      check($sformatf("sw_f%0d_first", f), {8'h0, dr_s, dg_s, db_s}, {8'h0, c, c, c});
      check($sformatf("sw_f%0d_fcnt", f), {24'h0, frame_cnt_s}, {24'h0, c});
      go_s(f, 1, 7);
      check($sformatf("sw_f%0d_last", f), {8'h0, dr_s, dg_s, db_s}, {8'h0, c, c, c});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_dac_sequencer.md
# rgb_dac_sequencer

Pixel-timing and pattern controller that produces the 24-bit digital colour words `dr`/`dg`/`db`, which the RGB buffer strip drives into the three 8-bit DACs. It generates 640x480 VGA-class raster timing (hsync, vsync, blank) and fills the visible area with a selectable pattern: black, colour bars, grey ramp, or a per-frame full-screen code sweep for DAC linearity characterisation. Configuration changes take effect only on frame boundaries, so a frame never tears mid-scan.

## Interface
Parameters:
- `H_VIS` = 640: visible pixels per line.
- `H_FP` = 16, `H_SYNC` = 96, `H_BP` = 48: horizontal porch and sync widths, in pixels.
- `V_VIS` = 480: visible lines per frame.
- `V_FP` = 10, `V_SYNC` = 2, `V_BP` = 33: vertical porch and sync widths, in lines.
- `SYNC_POL` = 0: asserted sync level (0 means active-low).

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset. One clock domain; reset is asynchronous and active-low.
- `mode` in 2: pattern select. 0 = BLACK, 1 = BARS, 2 = RAMP, 3 = SWEEP.
- `chan_en` in 3: channel mask `{r,g,b}`. A cleared bit forces that channel to 0.
- `dr`, `dg`, `db` out 8 each: registered colour codes to the buffers/DACs.
- `hsync`, `vsync` out 1 each: registered sync outputs at `SYNC_POL`.
- `blank` out 1: high outside the visible area.
- `frame_start` out 1: one-cycle pulse, coincident with pixel (0,0) on the outputs.
- `frame_cnt` out 8: number of completed frames, wrapping.

## Operation
- Counters `h` (0..H_TOTAL-1, H_TOTAL=800) and `v` (0..V_TOTAL-1, V_TOTAL=525).
  - `h` increments every clock.
  - When `h` reaches H_TOTAL-1, `h` wraps to 0 and `v` increments.
  - When `v` also reaches V_TOTAL-1 at that point, `v` wraps to 0.
- Visible area: `h < H_VIS && v < V_VIS`.
- hsync is asserted for `h` in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. 656..751 with the defaults.
- vsync is asserted for `v` in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], i.e. 490..491 with the defaults.
- End of frame (EOF) is the cycle where `h` = H_TOTAL-1 and `v` = V_TOTAL-1. On EOF:
  - `mode_q` ← `mode`;
  - `chan_q` ← `chan_en`;
  - `frame_cnt` ← `frame_cnt` + 1, wrapping 255→0.
  - `mode` and `chan_en` are ignored at every other cycle.
- Pattern value, computed only in the visible area:
  - BLACK: all channels 0.
  - BARS: 8 bars, each H_VIS/8 = 80 px wide. The bar index comes from a sub-counter (0..79) plus a 3-bit bar counter, both cleared at `h`=0; no divider. With code c = 7 − bar: r = c[2]?8'hFF:0, g = c[1]?8'hFF:0, b = c[0]?8'hFF:0. Bar 0 is therefore white and bar 7 black.
  - RAMP: all channels = `h[7:0]`, wrapping at 256 and 512 within the line.
  - SWEEP: all channels = the `frame_cnt` value latched at EOF, constant for the whole frame.
- Masking and blanking:
  - Each channel is ANDed with its `chan_q` bit.
  - Outside the visible area every channel is 0, in all modes.

## Timing
- All outputs are registered. Latency is exactly 1 clock from counter state to `dr/dg/db/hsync/vsync/blank/frame_start`, identical for every output, so they stay mutually aligned.
- Reset values:
  - `h` = `v` = 0;
  - `dr`/`dg`/`db` = 0;
  - `hsync` = `vsync` = ~SYNC_POL (deasserted);
  - `blank` = 1;
  - `frame_start` = 0;
  - `frame_cnt` = 0;
  - `mode_q` = BLACK; `chan_q` = 3'b111.
- First frame after reset release:
  - Counters start at (0,0) on the first clock edge after `rst_n` rises.
  - That first frame is BLACK regardless of `mode`.
  - `frame_start` does not pulse for it; the first pulse follows the first EOF.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously), and the frame restarts from (0,0).
- Inputs changed mid-frame have no visible effect until the next frame.
- Inputs changed exactly on the EOF cycle are taken.
- `frame_cnt` wrap: SWEEP shows code 255, then code 0 on the next frame.

## Structure
- Package `rgb_seq_pkg`:
  - mode enum `RGB_MODE_BLACK/BARS/RAMP/SWEEP`;
  - default timing constants;
  - derived totals H_TOTAL/V_TOTAL and the sync start/end constants.
- Sub-module `rgb_seq_timing`: the h/v counters, the sync/visible decode, and the EOF strobe.
- The top level holds the config latch, the pattern generator, and the output registers.

## Test plan
- Reset, then 1 frame with `mode`=BARS → all RGB outputs 0 for the entire first frame. `frame_start` first pulses 420000 clocks after reset release.
- BARS, `chan_en`=7 → on line 0, pixels 0..79 = FF/FF/FF, pixels 80..159 = FF/FF/00, pixels 560..639 = 00/00/00. Pixel 640 is blanked to 0.
- RAMP, `chan_en`=3'b010 → `dg` = 0..255, 0..255, 0..127 across the line; `dr` = `db` = 0.
- SWEEP over 258 frames → the screen code equals the frame index mod 256 and holds constant within each frame; 255 is followed by 0.
- Sync check → hsync low for 96 clocks starting at output cycle h=657 (1-clock latency). vsync low for lines 490–491. Each line is 800 clocks and each frame is 525 lines.
- Change `mode` at line 200 and pulse `rst_n` low at line 300:
  - no pattern change is visible at line 200;
  - outputs are at reset values immediately when `rst_n` goes low;
  - the next frame after release is BLACK.
